// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: issues radix-2 DIT butterfly read/write address pairs stage by stage
// over an in-place sample RAM, with a fixed-latency write-back pipeline.
module fft_stage_sequencer #(
    parameter int ADDR_WIDTH = 12,
    parameter int BF_LATENCY = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_DATA_LOADED,
    input  logic [ADDR_WIDTH-1:0] i_SAMPLES_NUMBER,
    output logic                  o_RD_EN,
    output logic [ADDR_WIDTH-1:0] o_ADDR_A,
    output logic [ADDR_WIDTH-1:0] o_ADDR_B,
    output logic [ADDR_WIDTH-2:0] o_TWIDDLE_IDX,
    output logic                  o_WR_EN,
    output logic [ADDR_WIDTH-1:0] o_WR_ADDR_A,
    output logic [ADDR_WIDTH-1:0] o_WR_ADDR_B,
    output logic [3:0]            o_STAGE,
    output logic                  o_BUSY,
    output logic                  o_CALC_END,
    output logic                  o_ERR
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
    localparam logic [3:0]            LAT = 4'(BF_LATENCY);

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_stage;
    logic [3:0]            r_log2;
    logic [3:0]            r_drain;
    logic [3:0]            w_log2;
    logic [ADDR_WIDTH-1:0] r_k;
    logic [ADDR_WIDTH-1:0] r_last_k;
    logic                  r_err;
    logic                  w_legal;
    logic                  w_last_k;
    logic                  w_last_stage;
    logic                  w_drain_end;
    logic [ADDR_WIDTH-1:0] w_half;
    logic [ADDR_WIDTH-1:0] w_pos;
    logic [ADDR_WIDTH-1:0] w_grp;
    logic [ADDR_WIDTH-1:0] w_addr_a;
    logic [ADDR_WIDTH-1:0] w_addr_b;
    logic [ADDR_WIDTH-2:0] w_tw;
    logic [2*ADDR_WIDTH:0] r_pipe [BF_LATENCY];

    // Legal sizes are powers of two from 2 up to the top address bit.
    assign w_legal = (i_SAMPLES_NUMBER > ONE) &&
                     ((i_SAMPLES_NUMBER & (i_SAMPLES_NUMBER - ONE)) == '0);

    always_comb begin
        w_log2 = '0;
        for (int i = 0; i < ADDR_WIDTH; i++)
            if (i_SAMPLES_NUMBER[i]) w_log2 = 4'(i);
    end

    assign w_last_k     = r_k == r_last_k;
    assign w_last_stage = r_stage == r_log2 - 4'd1;
    assign w_drain_end  = r_drain == 4'd1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (i_DATA_LOADED) w_next = w_legal ? ISSUE : IDLE;
            ISSUE:      if (w_last_k) w_next = DRAIN;
            DRAIN:      if (w_drain_end) w_next = w_last_stage ? DONE : ISSUE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_stage  <= '0;
            r_k      <= '0;
            r_drain  <= '0;
            r_log2   <= '0;
            r_last_k <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_DATA_LOADED) begin
                        r_err <= !w_legal;
                        if (w_legal) begin
                            r_stage  <= '0;
                            r_k      <= '0;
                            r_log2   <= w_log2;
                            r_last_k <= (i_SAMPLES_NUMBER >> 1) - ONE;
                        end
                    end
                end
                ISSUE: begin
                    r_k <= w_last_k ? '0 : r_k + ONE;
                    if (w_last_k) r_drain <= LAT;
                end
                DRAIN: begin
                    r_drain <= r_drain - 4'd1;
                    if (w_drain_end && !w_last_stage) r_stage <= r_stage + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Butterfly k of stage s: group grp, offset pos within a span of 2*half samples.
    assign w_half   = ONE << r_stage;
    assign w_pos    = r_k & (w_half - ONE);
    assign w_grp    = r_k >> r_stage;
    assign w_addr_a = (w_grp << (r_stage + 4'd1)) | w_pos;
    assign w_addr_b = w_addr_a + w_half;
    assign w_tw     = w_pos[ADDR_WIDTH-2:0] << (r_log2 - 4'd1 - r_stage);

    assign o_RD_EN       = r_state == ISSUE;
    assign o_ADDR_A      = o_RD_EN ? w_addr_a : '0;
    assign o_ADDR_B      = o_RD_EN ? w_addr_b : '0;
    assign o_TWIDDLE_IDX = o_RD_EN ? w_tw : '0;
    assign o_STAGE       = r_stage;
    assign o_BUSY        = (r_state == ISSUE) || (r_state == DRAIN);
    assign o_CALC_END    = r_state == DONE;
    assign o_ERR         = r_err;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < BF_LATENCY; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= {o_RD_EN, o_ADDR_A, o_ADDR_B};
            for (int i = 1; i < BF_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign {o_WR_EN, o_WR_ADDR_A, o_WR_ADDR_B} = r_pipe[BF_LATENCY-1];
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: table-driven runs plus hand sequences, with a scoreboard of
// expected read/write events (cycle, addresses, twiddle, stage) checked by a monitor.
module tb_fft_stage_sequencer;
    localparam int LAT = 4;

    typedef struct {int cyc; int a; int b; int tw; int st;} ev_t;
    typedef struct {int n; int exp_err; int exp_cyc;} vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        dl = 1'b0;
    logic [11:0] nsamp = '0;
    logic        o_RD_EN, o_WR_EN, o_BUSY, o_CALC_END, o_ERR;
    logic [11:0] o_ADDR_A, o_ADDR_B, o_WR_ADDR_A, o_WR_ADDR_B;
    logic [10:0] o_TWIDDLE_IDX;
    logic [3:0]  o_STAGE;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    ev_t  rdq[$];
    ev_t  wrq[$];
    ev_t  m_e;

    fft_stage_sequencer #(.ADDR_WIDTH(12), .BF_LATENCY(LAT)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_DATA_LOADED(dl), .i_SAMPLES_NUMBER(nsamp),
        .o_RD_EN(o_RD_EN), .o_ADDR_A(o_ADDR_A), .o_ADDR_B(o_ADDR_B),
        .o_TWIDDLE_IDX(o_TWIDDLE_IDX), .o_WR_EN(o_WR_EN), .o_WR_ADDR_A(o_WR_ADDR_A),
        .o_WR_ADDR_B(o_WR_ADDR_B), .o_STAGE(o_STAGE), .o_BUSY(o_BUSY),
        .o_CALC_END(o_CALC_END), .o_ERR(o_ERR)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int ilog2(input int n);
        int r = 0;
        while ((1 << (r + 1)) <= n) r++;
        return r;
    endfunction

    function automatic bit is_legal(input int n);
        return n >= 2 && n <= 2048 && (n & (n - 1)) == 0;
    endfunction

    // N=8 uses literal pair/twiddle lists; other sizes use the group/offset loop model.
    task automatic push_run(input int n, input int ts);
        int a8[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        int b8[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        int tw8[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
        int l = ilog2(n);
        int half, k;
        ev_t e;
        for (int s = 0; s < l; s++) begin
            half = 1 << s;
            k = 0;
            for (int j = 0; j < n; j += 2 * half)
                for (int p = 0; p < half; p++) begin
                    e.cyc = ts + 1 + s * (n / 2 + LAT) + k;
                    e.st  = s;
                    if (n == 8) begin
                        e.a  = a8[s * 4 + k];
                        e.b  = b8[s * 4 + k];
                        e.tw = tw8[s * 4 + k];
                    end else begin
                        e.a  = j + p;
                        e.b  = j + p + half;
                        e.tw = p * (n / (2 * half));
                    end
                    rdq.push_back(e);
                    e.cyc += LAT;
                    wrq.push_back(e);
                    k++;
                end
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (o_RD_EN) begin
                if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    m_e = rdq.pop_front();
                    chk("rd_cyc", cyc, m_e.cyc);
                    chk("rd_addr_a", int'(o_ADDR_A), m_e.a);
                    chk("rd_addr_b", int'(o_ADDR_B), m_e.b);
                    chk("rd_twiddle", int'(o_TWIDDLE_IDX), m_e.tw);
                    chk("rd_stage", int'(o_STAGE), m_e.st);
                end
                if (wrq.size() > 0) chk("rd_before_prev_wr", int'(o_STAGE), wrq[0].st);
            end else begin
                chk("idle_addr", int'(o_ADDR_A) | int'(o_ADDR_B) | int'(o_TWIDDLE_IDX), 0);
            end
            if (o_WR_EN) begin
                if (wrq.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    m_e = wrq.pop_front();
                    chk("wr_cyc", cyc, m_e.cyc);
                    chk("wr_addr_a", int'(o_WR_ADDR_A), m_e.a);
                    chk("wr_addr_b", int'(o_WR_ADDR_B), m_e.b);
                end
            end
        end
    end

    task automatic start(input int n, output int ts);
        @(negedge clk);
        dl = 1'b1;
        nsamp = 12'(n);
        ts = cyc;
        if (is_legal(n)) push_run(n, ts);
        @(negedge clk);
        dl = 1'b0;
    endtask

    task automatic wait_done(input int ts, input int exp_cyc);
        int k = 0;
        while (o_CALC_END !== 1'b1 && k < exp_cyc + 50) begin
            @(negedge clk);
            k++;
        end
        if (o_CALC_END !== 1'b1) begin
            chk("done_timeout", 0, 1);
            rdq.delete();
            wrq.delete();
        end else begin
            chk("run_cycles", cyc - ts - 1, exp_cyc);
            chk("done_busy", int'(o_BUSY), 0);
            chk("done_err", int'(o_ERR), 0);
            chk("done_rdq_left", rdq.size(), 0);
            chk("done_wrq_left", wrq.size(), 0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, int'(o_RD_EN), 0);
        chk({tag, "_wr_en"}, int'(o_WR_EN), 0);
        chk({tag, "_addr"}, int'(o_ADDR_A) | int'(o_ADDR_B) | int'(o_TWIDDLE_IDX), 0);
        chk({tag, "_wr_addr"}, int'(o_WR_ADDR_A) | int'(o_WR_ADDR_B), 0);
        chk({tag, "_stage"}, int'(o_STAGE), 0);
        chk({tag, "_busy"}, int'(o_BUSY), 0);
        chk({tag, "_calc_end"}, int'(o_CALC_END), 0);
        chk({tag, "_err"}, int'(o_ERR), 0);
    endtask

    initial begin
        vec_t tbl[7];
        int ts, k;
        // 4096 does not fit in 12 bits and arrives as 0, which must be rejected.
        tbl = '{'{8, 0, 24}, '{6, 1, 0}, '{4096, 1, 0}, '{4, 0, 12},
                '{2, 0, 5}, '{16, 0, 48}, '{2048, 0, 11308}};

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) begin
            start(tbl[i].n, ts);
            if (tbl[i].exp_err != 0) begin
                repeat (3) @(negedge clk);
                chk("illegal_err", int'(o_ERR), 1);
                chk("illegal_busy", int'(o_BUSY), 0);
            end else begin
                chk("start_busy", int'(o_BUSY), 1);
                chk("start_calc_end_drop", int'(o_CALC_END), 0);
                wait_done(ts, tbl[i].exp_cyc);
            end
        end

        // N=1024 with a stray start pulse mid-run, then CALC_END must hold.
        start(1024, ts);
        repeat (700) @(negedge clk);
        dl = 1'b1;
        nsamp = 12'd8;
        @(negedge clk);
        dl = 1'b0;
        wait_done(ts, 5160);
        chk("final_stage_1024", int'(o_STAGE), 9);
        repeat (20) @(negedge clk);
        chk("calc_end_hold", int'(o_CALC_END), 1);

        // Reset during stage 1 of N=16: outputs drop at once, no writes afterwards.
        start(16, ts);
        k = 0;
        while (o_STAGE != 4'd1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("reach_stage1", int'(o_STAGE), 1);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk_all_zero("midrun_reset");
        rdq.delete();
        wrq.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_idle", int'(o_BUSY), 0);
        start(16, ts);
        wait_done(ts, 48);
        repeat (LAT + 2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 Parameter: ADDR_WIDTH, 12, sample-RAM address width; matches the bridge sample-index width.
REQ-002 Parameter: BF_LATENCY, 4, fixed cycles from read-address issue to butterfly result valid (range 1..15).
REQ-003 i_clk  in  1  clock; all state changes on the rising edge.
REQ-004 i_rstn  in  1  reset, asynchronous, active-low.
REQ-005 i_DATA_LOADED  in  1  start pulse from the AXI bridge; all samples are in RAM in bit-reversed order.
REQ-006 i_SAMPLES_NUMBER  in  12  FFT size N; sampled on start.
REQ-007 o_RD_EN  out  1  butterfly operand read strobe.
REQ-008 o_ADDR_A / o_ADDR_B  out  12 each  read addresses of the butterfly operand pair.
REQ-009 o_TWIDDLE_IDX  out  11  twiddle ROM index, aligned with o_RD_EN.
REQ-010 o_WR_EN  out  1  result write strobe; o_RD_EN delayed by BF_LATENCY.
REQ-011 o_WR_ADDR_A / o_WR_ADDR_B  out  12 each  write-back addresses; read addresses delayed by BF_LATENCY.
REQ-012 o_STAGE  out  4  current stage index s.
REQ-013 o_BUSY  out  1  high in ISSUE and DRAIN.
REQ-014 o_CALC_END  out  1  level; drives the bridge i_CALC_END input.
REQ-015 o_ERR  out  1  sticky flag for an illegal N.

Function
REQ-016 States: IDLE, ISSUE, DRAIN, DONE; ISSUE and DRAIN are the only states with o_BUSY = 1.
REQ-017 Legal N: power of two, 2..2048; L = log2(N) is computed and registered on start.
REQ-018 IDLE: i_DATA_LOADED with legal N -> ISSUE, s=0, k=0, o_ERR cleared; illegal N -> stay IDLE, o_ERR=1.
REQ-019 ISSUE: each cycle o_RD_EN=1 for butterfly k (0..N/2-1); half=1<<s, pos=k&(half-1), grp=k>>s.
REQ-020 ISSUE address rule: o_ADDR_A=(grp<<(s+1))|pos; o_ADDR_B=o_ADDR_A+half; o_TWIDDLE_IDX=pos<<(L-1-s).
REQ-021 ISSUE exit: after k=N/2-1 is issued -> DRAIN, drain counter loaded with BF_LATENCY.
REQ-022 DRAIN: o_RD_EN=0 for BF_LATENCY cycles, so every write of stage s completes before any read of stage s+1.
REQ-023 DRAIN exit: s<L-1 -> ISSUE with s+1 and k=0; s=L-1 -> DONE.
REQ-024 Write pipeline: BF_LATENCY-deep shift register carrying {rd_en, addr_a, addr_b}; it runs in every state.
REQ-025 DONE: o_CALC_END=1, held until i_DATA_LOADED; DONE + i_DATA_LOADED starts a new run as in IDLE (one-cycle turnaround, o_CALC_END drops).
REQ-026 i_DATA_LOADED in ISSUE or DRAIN is ignored; the run in progress completes.
REQ-027 Compute time per run: L*(N/2+BF_LATENCY) cycles from first ISSUE cycle to DONE entry.
REQ-028 Outside ISSUE: o_ADDR_A, o_ADDR_B and o_TWIDDLE_IDX are driven 0; no X on any output.
REQ-029 Address arithmetic is done in ADDR_WIDTH bits; o_ADDR_B never exceeds N-1 (no wrap for legal N).
REQ-030 N=2: single stage, single butterfly (0,1), twiddle 0.

Reset
REQ-031 i_rstn low asynchronously forces IDLE and clears s, k, the drain counter and the write pipeline.
REQ-032 Reset values: all outputs 0, including o_ERR and o_CALC_END.
REQ-033 Reset mid-run aborts the run, with no o_WR_EN after reset asserts; after release the block waits for a new i_DATA_LOADED.

Verification
REQ-034 N=8, LAT=4, start -> stage0 pairs (0,1)(2,3)(4,5)(6,7) tw 0,0,0,0.
REQ-035 Same run, stage1 -> pairs (0,2)(1,3)(4,6)(5,7) tw 0,2,0,2; stage2 -> pairs (0,4)(1,5)(2,6)(3,7) tw 0,1,2,3; DONE after 24 cycles.
REQ-036 Write check on the N=8 run -> each o_WR_EN occurs exactly 4 cycles after its o_RD_EN with the same addresses; no o_RD_EN while any write of the previous stage is pending.
REQ-037 N=6 and N=4096 each -> o_ERR=1, stays IDLE, o_RD_EN never asserted; a following legal start clears o_ERR.
REQ-038 N=1024 run -> 10 stages, 5160 cycles, o_CALC_END held until the next start; a start pulse mid-run is ignored.
REQ-039 Reset asserted in stage 1 of N=16 -> all outputs 0 immediately, no writes afterward; a fresh start then completes normally.
